// File: rtl/stitch_egress_pkg.sv
// rtl/stitch_egress_pkg.sv - shared defaults and width helpers for the stitch pipeline egress adapter
package stitch_egress_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int LATENCY_DEF = 3;
    localparam int DEPTH_DEF   = 5;

    // Width needed to hold 0..depth (credit counter and FIFO occupancy)
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a FIFO pointer; never narrower than one bit
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/stitch_egress_fifo.sv
// rtl/stitch_egress_fifo.sv - DATA_W x DEPTH synchronous FIFO with full/empty/count, any DEPTH
module stitch_egress_fifo
    import stitch_egress_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = credit_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    // A write into a full FIFO is accepted only when a pop frees the slot in the same cycle
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage array: no reset, contents are qualified by count
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
        end
    end

    // Occupancy: simultaneous write and pop leave it unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stitch_pipeline_egress.sv
// rtl/stitch_pipeline_egress.sv - credit adapter around a stall-free pipeline; optional STITCH_PIPELINE_EGRESS_LATENCY_CHECK_EN
module stitch_pipeline_egress
    import stitch_egress_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = LATENCY_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         up_valid,
    input  logic [DATA_W-1:0]            up_data,
    output logic                         up_ready,
    output logic                         pipe_in_valid,
    output logic [DATA_W-1:0]            pipe_in_data,
    input  logic                         pipe_out_valid,
    input  logic [DATA_W-1:0]            pipe_out_data,
    output logic                         dn_valid,
    output logic [DATA_W-1:0]            dn_data,
    input  logic                         dn_ready,
    output logic [$clog2(DEPTH+1)-1:0]   credits,
    output logic                         overflow,
    output logic                         latency_err
);

    localparam int CW = credit_w(DEPTH);

    logic          issue;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] unused_fifo_count;

    // Each credit is a reserved FIFO slot, so the pipeline can never outrun the buffer
    assign up_ready      = (credits != '0);
    assign issue         = up_valid && up_ready;
    assign pipe_in_valid = issue;
    assign pipe_in_data  = up_data;
    assign dn_valid      = !fifo_empty;
    assign pop           = dn_valid && dn_ready;

    stitch_egress_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pipe_out_valid),
        .wr_data (pipe_out_data),
        .rd_en   (dn_ready),
        .rd_data (dn_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (unused_fifo_count)
    );

    // Credit counter: take one per issue, return one per pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits <= CW'(DEPTH);
        end else if (issue && !pop) begin
            credits <= credits - CW'(1);
        end else if (pop && !issue) begin
            credits <= credits + CW'(1);
        end
    end

    // Sticky flag for a result that found no room; the word itself is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (pipe_out_valid && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef STITCH_PIPELINE_EGRESS_LATENCY_CHECK_EN
    logic [LATENCY-1:0] issue_sr;

    // Shadow of the pipeline valid chain; any disagreement with pipe_out_valid is sticky
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_sr    <= '0;
            latency_err <= 1'b0;
        end else begin
            issue_sr <= LATENCY'({issue_sr, issue});
            if (pipe_out_valid != issue_sr[LATENCY-1]) begin
                latency_err <= 1'b1;
            end
        end
    end
`else
    assign latency_err = 1'b0;
`endif

endmodule
